fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Generates next_pc and the F-stage stall that drive the instruction-memory/PC register.
//  Merges sequential fetch, D-stage branch and jr redirects, hazard stalls, halt/resume and bad-target detection.
//  Holds redirects that arrive during a stall and applies them once the stall releases.
//  Sits between the hazard unit / D-stage compare logic and the fetch stage.
// PARAMETERS
//  RESET_PC     32'h0000_3000  first fetch address, base of instruction memory
//  IM_WORDS     4096           instruction memory depth in words; legal range RESET_PC..RESET_PC+4*IM_WORDS-4
//  TRAP_VECTOR  32'h0000_4180  fault handler address (used only with FETCH_TRAP_EN)
//  CNT_W        16             width of redirect_count
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  reset          in   1      asynchronous, active-low reset
//  pc_f           in   32     PC currently held in the fetch stage
//  hazard_stall   in   1      stall request from the hazard unit
//  br_valid       in   1      taken-branch redirect from the D stage
//  br_target      in   32     branch target
//  jr_valid       in   1      jr/jalr redirect from the D stage
//  jr_target      in   32     register jump target
//  halt_req       in   1      freeze fetch (level-sensitive)
//  resume         in   1      leave HALT
//  next_pc        out  32     PC for the fetch register to load on the next edge
//  stall_f        out  1      1 = fetch register holds its value
//  state          out  2      0 BOOT, 1 RUN, 2 HALT, 3 FAULT
//  fetch_fault    out  1      illegal target detected
//  epc            out  32     last faulting target
//  redirect_count out  CNT_W  number of applied redirects, saturating
// BEHAVIOUR
//  Reset (reset=0): state=BOOT, pend_v=0, pend_pc=0, epc=0, redirect_count=0, fetch_fault=0.
//  Reset is asynchronous; mid-operation assertion clears everything immediately, including a pending redirect.
//  next_pc and stall_f are combinational from state, registers and inputs; a redirect takes effect on the same edge.
//  The redirect source is rd = jr when jr_valid, else br when br_valid (jr wins when both are valid).
//  BOOT: stall_f=1, next_pc=pc_f. Moves to RUN after one cycle.
//  RUN, first matching case applies:
//   halt_req=1: stall_f=1, next_pc=pc_f, ->HALT. A redirect valid in the same cycle is latched into pend.
//   hazard_stall=1: stall_f=1, next_pc=pc_f. A valid rd is latched into pend_pc/pend_v, overwriting any older pend.
//   otherwise: stall_f=0. tgt = rd if valid, else pend_pc if pend_v, else pc_f+4 (mod 2^32). pend_v clears.
//   redirect_count increments when tgt comes from rd or pend. It saturates at all ones.
//  Target check, done only when stall_f=0:
//   The target is illegal if tgt[1:0]!=0, tgt<RESET_PC, or tgt>RESET_PC+4*IM_WORDS-4.
//   The comparison is done in 33 bits so it cannot overflow.
//   An illegal target loads epc<=tgt.
//  HALT: stall_f=1, next_pc=pc_f. resume=1 -> RUN on the next edge; pend is kept. halt_req has no effect while in HALT.
//  FAULT: stall_f=1, next_pc=pc_f, fetch_fault=1. The only exit is reset.
//  Output defaults: next_pc=pc_f whenever stall_f=1.
// CONFIGURATION
//  FETCH_TRAP_EN undefined:
//   An illegal target forces next_pc=pc_f and stall_f=1 in that cycle, then ->FAULT.
//   fetch_fault stays high until reset.
//  FETCH_TRAP_EN defined:
//   An illegal target gives next_pc=TRAP_VECTOR, stall_f=0, fetch_fault=1 for exactly that cycle.
//   State stays RUN and redirect_count increments. The FAULT state is unreachable.
// TESTING
//  1. Release reset with pc_f=0x3000: one BOOT cycle with stall_f=1, then next_pc=0x3004,0x3008,... with stall_f=0.
//  2. RUN, pc_f=0x3010, br_valid=1 (target 0x3040) and jr_valid=1 (target 0x3100) together -> next_pc=0x3100, count=1.
//  3. hazard_stall=1 for 3 cycles with a one-cycle br_valid (target 0x3200) in cycle 1 -> stall_f=1 throughout.
//     The cycle after the stall drops gives next_pc=0x3200 and pend_v=0.
//  4. br_target=0x3002, FETCH_TRAP_EN off -> state=FAULT, epc=0x3002, stall_f stuck at 1.
//     FETCH_TRAP_EN on -> next_pc=0x4180 and a one-cycle fetch_fault.
//  5. pc_f=0x6FFC in sequential fetch -> 0x7000 is illegal, fault handled per item 4.
//     Assert reset mid-FAULT -> all outputs at reset values.
//  6. halt_req=1 in RUN -> HALT with stall_f=1. resume=1 -> RUN on the next edge, fetch continues from pc_f+4.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - next-PC / F-stage stall sequencer with pending redirects and bad-target detection.
// Define FETCH_TRAP_EN to vector illegal targets to TRAP_VECTOR instead of freezing in FAULT.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          IM_WORDS    = 4096,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_4180,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    input  logic             hazard_stall,
    input  logic             br_valid,
    input  logic [31:0]      br_target,
    input  logic             jr_valid,
    input  logic [31:0]      jr_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      next_pc,
    output logic             stall_f,
    output logic [1:0]       state,
    output logic             fetch_fault,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // 33-bit bounds so RESET_PC + 4*IM_WORDS cannot wrap
    localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
    localparam logic [32:0] PC_HI = {1'b0, RESET_PC} + 33'(4 * IM_WORDS) - 33'd4;

    state_t            state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic [31:0]       epc_q, epc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rd_v;
    logic [31:0]       rd_pc;
    logic [31:0]       tgt;
    logic              tgt_bad;
    logic [CNT_W-1:0]  cnt_inc;

    assign rd_v    = jr_valid | br_valid;
    assign rd_pc   = jr_valid ? jr_target : br_target;
    assign tgt     = rd_v ? rd_pc : (pend_v_q ? pend_pc_q : pc_f + 32'd4);
    assign tgt_bad = (tgt[1:0] != 2'b00) || ({1'b0, tgt} < PC_LO) || ({1'b0, tgt} > PC_HI);
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            pend_v_q  <= 1'b0;
            pend_pc_q <= 32'd0;
            epc_q     <= 32'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
            epc_q     <= epc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_pc_d   = pend_pc_q;
        epc_d       = epc_q;
        cnt_d       = cnt_q;
        next_pc     = pc_f;
        stall_f     = 1'b1;
        fetch_fault = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (halt_req || hazard_stall) begin
                    // A redirect seen while frozen is parked until fetch resumes
                    if (rd_v) begin
                        pend_v_d  = 1'b1;
                        pend_pc_d = rd_pc;
                    end
                    if (halt_req) state_d = S_HALT;
                end else begin
                    pend_v_d = 1'b0;
                    if (tgt_bad) begin
                        epc_d       = tgt;
                        fetch_fault = 1'b1;
`ifdef FETCH_TRAP_EN
                        stall_f = 1'b0;
                        next_pc = TRAP_VECTOR;
                        cnt_d   = cnt_inc;
`else
                        state_d = S_FAULT;
`endif
                    end else begin
                        stall_f = 1'b0;
                        next_pc = tgt;
                        if (rd_v || pend_v_q) cnt_d = cnt_inc;
                    end
                end
            end
            S_HALT: if (resume) state_d = S_RUN;
            S_FAULT: fetch_fault = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end

    assign state          = state_q;
    assign epc            = epc_q;
    assign redirect_count = cnt_q;

endmodule
